// File: rtl/sparse_array_pkg.sv
// Shared FSM encoding and saturation limits for the sparse MAC array.
package sparse_array_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDrain = 2'd2
    } state_e;

    function automatic logic signed [63:0] sat_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/sparse_mac_pe.sv
// Mask-gated saturating signed multiply-accumulate cell.
module sparse_mac_pe
    import sparse_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32
) (
    input  logic                         Clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] act,
    input  logic signed [DATA_WIDTH-1:0] w,
    output logic signed [ACC_WIDTH-1:0]  acc,
    output logic                         sat
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

    logic signed [PW-1:0]        act_x;
    logic signed [PW-1:0]        w_x;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH:0]   sum;
    logic                        ovf;
    logic signed [ACC_WIDTH-1:0] acc_next;

    assign act_x = {{DATA_WIDTH{act[DATA_WIDTH-1]}}, act};
    assign w_x   = {{DATA_WIDTH{w[DATA_WIDTH-1]}}, w};
    assign prod  = act_x * w_x;
    // One guard bit: overflow shows up as disagreement between the top two bits.
    assign sum   = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH + 1 - PW){prod[PW-1]}}, prod};
    assign ovf   = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign sat   = en & ovf;

    always_comb begin
        acc_next = sum[ACC_WIDTH-1:0];
        if (ovf) begin
            acc_next = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/sparse_systolic_array.sv
// ROWS x COLS sparse MAC grid with job sequencer: accumulate k_len beats, then drain one row per beat.
module sparse_systolic_array
    import sparse_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned KLEN_WIDTH = 8,
    localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                          Clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [KLEN_WIDTH-1:0]         k_len,
    input  logic [ROWS*DATA_WIDTH-1:0]    Input_act,
    input  logic [COLS*DATA_WIDTH-1:0]    Input_weight,
    input  logic [ROWS*COLS-1:0]          mask,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [COLS*ACC_WIDTH-1:0]     out_data,
    output logic [ROW_W-1:0]              out_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          sat_flag,
    output logic [15:0]                   skip_count
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_e                      state;
    logic [KLEN_WIDTH-1:0]       k_len_q;
    logic [KLEN_WIDTH-1:0]       beat;
    logic [ROW_W-1:0]            ptr;
    logic                        clr;
    logic                        accept;
    logic                        last_beat;
    logic [ROWS*COLS-1:0]        pe_sat;
    logic signed [ACC_WIDTH-1:0] acc [ROWS][COLS];
    logic [16:0]                 skip_inc;
    logic [16:0]                 skip_sum;

    assign in_ready  = (state == StAccum);
    assign out_valid = (state == StDrain);
    assign busy      = (state != StIdle);
    assign out_row   = ptr;
    assign clr       = (state == StIdle) & start;
    assign accept    = in_ready & in_valid;
    assign last_beat = ({1'b0, beat} + (KLEN_WIDTH + 1)'(1)) == {1'b0, k_len_q};

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sparse_mac_pe #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .Clk(Clk),
                .rst(rst),
                .clr(clr),
                .en (accept & mask[r*COLS+c]),
                .act(Input_act[r*DATA_WIDTH +: DATA_WIDTH]),
                .w  (Input_weight[c*DATA_WIDTH +: DATA_WIDTH]),
                .acc(acc[r][c]),
                .sat(pe_sat[r*COLS+c])
            );
        end
    end

    always_comb begin
        out_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (ptr == ROW_W'(r)) begin
                for (int c = 0; c < COLS; c++) begin
                    out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc[r][c];
                end
            end
        end
    end

    // Masked-off products this beat, folded into a 16-bit saturating total.
    always_comb begin
        skip_inc = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (!mask[i]) begin
                skip_inc = skip_inc + 17'd1;
            end
        end
        skip_sum = {1'b0, skip_count} + skip_inc;
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            k_len_q    <= '0;
            beat       <= '0;
            ptr        <= '0;
            sat_flag   <= 1'b0;
            skip_count <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        k_len_q    <= k_len;
                        beat       <= '0;
                        ptr        <= '0;
                        sat_flag   <= 1'b0;
                        skip_count <= '0;
                        state      <= (k_len == '0) ? StDrain : StAccum;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        beat       <= beat + 1'b1;
                        sat_flag   <= sat_flag | (|pe_sat);
                        skip_count <= skip_sum[16] ? 16'hFFFF : skip_sum[15:0];
                        if (last_beat) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        if (ptr == LAST_ROW) begin
                            ptr   <= '0;
                            state <= StIdle;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_systolic_array.sv
// Directed bench: table-driven jobs plus hand sequences for reset, saturation, backpressure, k_len=0.
module tb_sparse_systolic_array;

    logic         Clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   k_len;
    logic [31:0]  Input_act;
    logic [31:0]  Input_weight;
    logic [15:0]  mask;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready,  in_ready_s;
    logic [127:0] out_data;
    logic [67:0]  out_data_s;
    logic [1:0]   out_row,   out_row_s;
    logic         out_valid, out_valid_s;
    logic         busy,      busy_s;
    logic         sat_flag,  sat_flag_s;
    logic [15:0]  skip_count, skip_count_s;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]        k;
        logic [31:0]       act;
        logic [31:0]       w;
        logic [15:0]       m;
        logic [3:0][127:0] exp;
        logic [15:0]       skip;
    } vec_t;

    vec_t vecs [4];

    sparse_systolic_array u_dut (
        .Clk(Clk), .rst(rst), .start(start), .k_len(k_len),
        .Input_act(Input_act), .Input_weight(Input_weight), .mask(mask),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_row(out_row),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .sat_flag(sat_flag),
        .skip_count(skip_count)
    );

    // Same stimulus into a narrow-accumulator copy to exercise clamping.
    sparse_systolic_array #(.ACC_WIDTH(17)) u_sat (
        .Clk(Clk), .rst(rst), .start(start), .k_len(k_len),
        .Input_act(Input_act), .Input_weight(Input_weight), .mask(mask),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s), .out_row(out_row_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .busy(busy_s), .sat_flag(sat_flag_s),
        .skip_count(skip_count_s)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    function automatic logic [127:0] row4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic feed(input logic [7:0] k, input logic [31:0] a, input logic [31:0] wt,
                        input logic [15:0] m);
        start = 1'b1;
        k_len = k;
        tick();
        start        = 1'b0;
        Input_act    = a;
        Input_weight = wt;
        mask         = m;
        for (int i = 0; i < int'(k); i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_check(input string tag, input logic [3:0][127:0] exp,
                               input logic chk_s, input logic [3:0][67:0] exp_s,
                               input logic [15:0] skip);
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("%s valid r%0d", tag, r), out_valid, 1);
            chk($sformatf("%s row r%0d", tag, r), out_row, r);
            chk($sformatf("%s data r%0d", tag, r), out_data, exp[r]);
            if (chk_s) chk($sformatf("%s sat data r%0d", tag, r), out_data_s, exp_s[r]);
            tick();
        end
        out_ready = 1'b0;
        chk({tag, " idle"}, busy, 0);
        chk({tag, " skip"}, skip_count, skip);
    endtask

    initial begin
        logic [3:0][127:0] ex;
        logic [3:0][67:0]  ex_s;
        logic [5:0]        pat;

        vecs[0].k = 8'd2; vecs[0].act = 32'h01010101; vecs[0].w = 32'h04030201;
        vecs[0].m = 16'hFFFF; vecs[0].skip = 16'd0;
        for (int r = 0; r < 4; r++) vecs[0].exp[r] = row4(2, 4, 6, 8);

        vecs[1].k = 8'd3; vecs[1].act = 32'h05050505; vecs[1].w = 32'h03030303;
        vecs[1].m = 16'h0001; vecs[1].skip = 16'd45;
        vecs[1].exp[0] = row4(45, 0, 0, 0);
        for (int r = 1; r < 4; r++) vecs[1].exp[r] = '0;

        // act {-1,2,-3,4}, w {5,-6,7,-8}
        vecs[2].k = 8'd1; vecs[2].act = 32'h04FD02FF; vecs[2].w = 32'hF807FA05;
        vecs[2].m = 16'hFFFF; vecs[2].skip = 16'd0;
        vecs[2].exp[0] = row4(-5, 6, -7, 8);
        vecs[2].exp[1] = row4(10, -12, 14, -16);
        vecs[2].exp[2] = row4(-15, 18, -21, 24);
        vecs[2].exp[3] = row4(20, -24, 28, -32);

        vecs[3].k = 8'd2; vecs[3].act = 32'h04030201; vecs[3].w = 32'h01010101;
        vecs[3].m = 16'h00FF; vecs[3].skip = 16'd16;
        vecs[3].exp[0] = row4(2, 2, 2, 2);
        vecs[3].exp[1] = row4(4, 4, 4, 4);
        vecs[3].exp[2] = '0;
        vecs[3].exp[3] = '0;

        rst = 1'b0; start = 1'b0; k_len = '0; Input_act = '0; Input_weight = '0;
        mask = '0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_row", out_row, 0);
        chk("reset sat_flag", sat_flag, 0);
        chk("reset skip", skip_count, 0);
        #10 rst = 1'b1;
        tick();

        // Reset mid-ACCUM after two accepted beats
        start = 1'b1; k_len = 8'd4;
        tick();
        start = 1'b0; Input_act = 32'h05050505; Input_weight = 32'h03030303;
        mask = 16'h000F; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("midjob busy", busy, 1);
        chk("midjob skip", skip_count, 24);
        #2 rst = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort in_ready", in_ready, 0);
        chk("abort out_valid", out_valid, 0);
        chk("abort sat_flag", sat_flag, 0);
        chk("abort skip", skip_count, 0);
        #2 rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            feed(vecs[i].k, vecs[i].act, vecs[i].w, vecs[i].m);
            chk($sformatf("vec%0d sat_flag", i), sat_flag, 0);
            drain_check($sformatf("vec%0d", i), vecs[i].exp, 1'b0, '0, vecs[i].skip);
        end

        // Saturation: (-128)*(-128)*4 = 65536 clamps to 65535 in 17 bits
        feed(8'd4, 32'h80808080, 32'h80808080, 16'hFFFF);
        for (int r = 0; r < 4; r++) begin
            ex[r]   = row4(65536, 65536, 65536, 65536);
            ex_s[r] = {4{17'h0FFFF}};
        end
        drain_check("sat", ex, 1'b1, ex_s, 16'd0);
        chk("sat flag narrow", sat_flag_s, 1);
        chk("sat flag wide", sat_flag, 0);
        feed(8'd2, 32'h01010101, 32'h04030201, 16'hFFFF);
        for (int r = 0; r < 4; r++) begin
            ex[r]   = row4(2, 4, 6, 8);
            ex_s[r] = {17'd8, 17'd6, 17'd4, 17'd2};
        end
        drain_check("post-sat", ex, 1'b1, ex_s, 16'd0);
        chk("post-sat flag", sat_flag_s, 0);

        // Backpressure: input gaps carry junk activations that must not accumulate
        start = 1'b1; k_len = 8'd3;
        tick();
        start = 1'b0; Input_weight = 32'h01010101; mask = 16'hFFFF;
        pat = 6'b101001;
        for (int i = 0; i < 6; i++) begin
            in_valid  = pat[i];
            Input_act = pat[i] ? 32'h04030201 : 32'h7F7F7F7F;
            chk($sformatf("bp in_ready %0d", i), in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        ex[0] = row4(3, 3, 3, 3);
        ex[1] = row4(6, 6, 6, 6);
        ex[2] = row4(9, 9, 9, 9);
        ex[3] = row4(12, 12, 12, 12);
        out_ready = 1'b1;
        chk("bp row0 valid", out_valid, 1);
        chk("bp row0 data", out_data, ex[0]);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp stall valid %0d", i), out_valid, 1);
            chk($sformatf("bp stall row %0d", i), out_row, 1);
            chk($sformatf("bp stall data %0d", i), out_data, ex[1]);
            tick();
        end
        out_ready = 1'b1;
        for (int r = 1; r < 4; r++) begin
            chk($sformatf("bp row %0d", r), out_row, r);
            chk($sformatf("bp data %0d", r), out_data, ex[r]);
            tick();
        end
        out_ready = 1'b0;
        chk("bp idle", busy, 0);

        // k_len=0 drains cleared rows; start during DRAIN is ignored
        start = 1'b1; k_len = 8'd0;
        tick();
        start = 1'b0;
        chk("k0 valid", out_valid, 1);
        chk("k0 row0", out_row, 0);
        chk("k0 data0", out_data, 0);
        out_ready = 1'b1;
        tick();
        start = 1'b1; k_len = 8'd1;
        for (int r = 1; r < 4; r++) begin
            chk($sformatf("k0 row %0d", r), out_row, r);
            chk($sformatf("k0 data %0d", r), out_data, 0);
            chk($sformatf("k0 in_ready %0d", r), in_ready, 0);
            tick();
        end
        out_ready = 1'b0;
        chk("k0 final ignored", busy, 0);
        tick();
        start = 1'b0;
        chk("k0 restart busy", busy, 1);
        chk("k0 restart in_ready", in_ready, 1);
        Input_act = 32'h01010101; Input_weight = 32'h01010101; mask = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int r = 0; r < 4; r++) ex[r] = row4(1, 1, 1, 1);
        drain_check("restart", ex, 1'b0, '0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
